text_memory_latency_model: RTL

Pipelined, variable-latency instruction (text) memory for simulation and FPGA bring-up of the multicycle and pipelined cores. It sits directly upstream of `text_memory_interface`, answering its `inst_read_enable` requests with `inst_wait_req`, `inst_valid` and `inst_data`. Fixed read latency and pseudo-random wait-request stalls exercise the core's instruction-holding and stall paths. A side-band load port preloads or patches program words.

---
 rtl/text_memory_latency_model.sv | 94 +++++++++
 1 files changed

// File: rtl/text_memory_latency_model.sv
// Variable-latency instruction memory model: fixed-depth read pipeline,
// LFSR-driven wait-request stalls and a side-band load port for program words.
module text_memory_latency_model #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned WAIT_MODE  = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_addr,
    input  logic        inst_read_enable,
    output logic        inst_wait_req,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    input  logic        load_enable,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LFSR_W   = 16;
    localparam logic        WAIT_EN  = (WAIT_MODE == 1);
    localparam logic        WAIT_RST = WAIT_EN & LFSR_SEED[0] & ~LFSR_SEED[3];

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [ADDR_WIDTH-1:0] ld_word;
    logic                  accept;

    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0]     data_q [LATENCY];
    logic [DATA_W-1:0]     data_d [LATENCY];
    logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
    logic                  wait_req_q, wait_req_d;

    // Byte offset and bits above the word index are don't-care (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH+2], inst_addr[1:0],
                                load_addr[31:ADDR_WIDTH+2], load_addr[1:0]};

    assign rd_word = inst_addr[ADDR_WIDTH+1:2];
    assign ld_word = load_addr[ADDR_WIDTH+1:2];

    // Load port; a same-cycle read still sees the pre-write word.
    always_ff @(posedge clock) begin
        if (!reset && load_enable) begin
            mem[ld_word] <= load_data;
        end
    end

    // Next-state: LFSR step, wait request, read pipeline advance.
    always_comb begin
        lfsr_d     = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        wait_req_d = WAIT_EN & lfsr_d[0] & ~lfsr_d[3];
        accept     = inst_read_enable && !wait_req_q;

        valid_d[0] = accept;
        data_d[0]  = mem[rd_word];
        for (int unsigned i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        // The last stage is also the output register: it holds between responses.
        if (!valid_d[LATENCY-1]) begin
            data_d[LATENCY-1] = data_q[LATENCY-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            wait_req_q <= WAIT_RST;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            lfsr_q     <= lfsr_d;
            wait_req_q <= wait_req_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign inst_wait_req = wait_req_q;
    assign inst_valid    = valid_q[LATENCY-1];
    assign inst_data     = data_q[LATENCY-1];

endmodule
